// File: rtl/dff_bank_arb_if.sv
// Bundle of request, grant, completion and bank-control signals between the
// requesters, the arbiter and the shared flip-flop bank.
interface dff_bank_arb_if #(
   parameter int unsigned W    = 8,
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [2*NREQ-1:0] cmd;
   logic [W*NREQ-1:0] wdata;
   logic [W-1:0]      bank_q;
   logic [W-1:0]      bank_d;
   logic              bank_we;
   logic              bank_s;
   logic              bank_r;
   logic              bank_sync;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   ack;
   logic [W-1:0]      rdata;
   logic              busy;

   // Arbiter side: owns the bank controls, grants and completions.
   modport master (
      input  req, cmd, wdata, bank_q,
      output bank_d, bank_we, bank_s, bank_r, bank_sync, gnt, ack, rdata, busy
   );

   // Requester / bank side.
   modport slave (
      output req, cmd, wdata, bank_q,
      input  bank_d, bank_we, bank_s, bank_r, bank_sync, gnt, ack, rdata, busy
   );
endinterface

// File: rtl/dff_bank_arb.sv
// Round-robin arbiter and command sequencer for a shared W-bit D flip-flop bank.
// Each granted transaction runs IDLE -> ISSUE -> DONE; every output except
// bank_sync is registered and reflects the state being entered.
module dff_bank_arb #(
   parameter int unsigned W         = 8,
   parameter int unsigned NREQ      = 4,
   parameter bit          SYNC_MODE = 1'b1
) (
   input logic            clk,
   input logic            r,
   dff_bank_arb_if.master bus
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] CmdLoad  = 2'b00;
   localparam logic [1:0] CmdSet   = 2'b01;
   localparam logic [1:0] CmdClear = 2'b10;
   localparam logic [1:0] CmdRead  = 2'b11;

   typedef enum logic [1:0] {StInit, StIdle, StIssue, StDone} state_e;

   state_e          r_state;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_win;
   logic [1:0]      r_cmd;
   logic [W-1:0]    r_bank_d;
   logic            r_bank_we;
   logic            r_bank_s;
   logic            r_bank_r;
   logic [NREQ-1:0] r_gnt;
   logic [NREQ-1:0] r_ack;
   logic [W-1:0]    r_rdata;
   logic            r_busy;

   logic            w_any;
   logic [PW-1:0]   w_win;
   logic [NREQ-1:0] w_win_oh;
   logic [1:0]      w_win_cmd;
   logic [W-1:0]    w_win_data;

   // Round-robin pick: first pass covers r_ptr..NREQ-1, second pass wraps to 0..r_ptr-1.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (!w_any && bus.req[i] && (PW'(i) >= r_ptr)) begin
            w_any = 1'b1;
            w_win = PW'(i);
         end
      end
      for (int i = 0; i < int'(NREQ); i++) begin
         if (!w_any && bus.req[i] && (PW'(i) < r_ptr)) begin
            w_any = 1'b1;
            w_win = PW'(i);
         end
      end
   end

   // Select the winner's command, data and one-hot grant.
   always_comb begin
      w_win_oh   = '0;
      w_win_cmd  = CmdLoad;
      w_win_data = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (PW'(i) == w_win) begin
            w_win_oh[i] = 1'b1;
            w_win_cmd   = bus.cmd[2*i +: 2];
            w_win_data  = bus.wdata[W*i +: W];
         end
      end
   end

   // Sequencer FSM with registered outputs; reset aborts any transaction without ack.
   always_ff @(posedge clk) begin
      if (r) begin
         r_state   <= StInit;
         r_ptr     <= '0;
         r_win     <= '0;
         r_cmd     <= CmdLoad;
         r_bank_d  <= '0;
         r_bank_we <= 1'b0;
         r_bank_s  <= 1'b0;
         r_bank_r  <= 1'b0;
         r_gnt     <= '0;
         r_ack     <= '0;
         r_rdata   <= '0;
         r_busy    <= 1'b1;
      end else begin
         unique case (r_state)
            StInit: begin
               // First cycle out of reset drives the clear; the next one enters IDLE.
               if (!r_bank_r) begin
                  r_bank_r  <= 1'b1;
                  r_bank_we <= 1'b1;
               end else begin
                  r_bank_r  <= 1'b0;
                  r_bank_we <= 1'b0;
                  r_busy    <= 1'b0;
                  r_state   <= StIdle;
               end
            end
            StIdle: begin
               if (w_any) begin
                  r_state   <= StIssue;
                  r_busy    <= 1'b1;
                  r_gnt     <= w_win_oh;
                  r_win     <= w_win;
                  r_cmd     <= w_win_cmd;
                  r_bank_we <= (w_win_cmd != CmdRead);
                  r_bank_d  <= (w_win_cmd == CmdLoad) ? w_win_data : '0;
                  r_bank_s  <= (w_win_cmd == CmdSet);
                  r_bank_r  <= (w_win_cmd == CmdClear);
               end
            end
            StIssue: begin
               r_bank_we <= 1'b0;
               r_bank_d  <= '0;
               r_bank_s  <= 1'b0;
               r_bank_r  <= 1'b0;
               r_ack     <= r_gnt;
               r_state   <= StDone;
            end
            StDone: begin
               // bank_q already holds the post-ISSUE value here.
               if (r_cmd == CmdRead) begin
                  r_rdata <= bus.bank_q;
               end
               r_ptr   <= (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;
               r_ack   <= '0;
               r_gnt   <= '0;
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StInit;
         endcase
      end
   end

   assign bus.bank_d    = r_bank_d;
   assign bus.bank_we   = r_bank_we;
   assign bus.bank_s    = r_bank_s;
   assign bus.bank_r    = r_bank_r;
   assign bus.bank_sync = SYNC_MODE;
   assign bus.gnt       = r_gnt;
   assign bus.ack       = r_ack;
   assign bus.rdata     = r_rdata;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_dff_bank_arb.sv
// Bench for dff_bank_arb: directed requester stimulus, a behavioural flip-flop
// bank, and a scoreboard monitor that checks every ack and read result.
module tb_dff_bank_arb;

   localparam int unsigned W    = 8;
   localparam int unsigned NREQ = 4;

   localparam logic [1:0] CmdLoad  = 2'b00;
   localparam logic [1:0] CmdSet   = 2'b01;
   localparam logic [1:0] CmdClear = 2'b10;
   localparam logic [1:0] CmdRead  = 2'b11;

   typedef struct {
      int         idx;
      bit         is_read;
      logic [7:0] rd;
   } exp_t;

   logic        clk;
   logic        r;
   logic [3:0]  req_v;
   logic [7:0]  cmd_v;
   logic [31:0] wdata_v;
   logic [7:0]  bank = 8'h5A;
   bit   [3:0]  hold;
   int          cyc;
   int          n_checks;
   int          n_err;
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [3:0]  mon_oh;

   dff_bank_arb_if #(.W(W), .NREQ(NREQ)) bus ();

   assign bus.req    = req_v;
   assign bus.cmd    = cmd_v;
   assign bus.wdata  = wdata_v;
   assign bus.bank_q = bank;

   dff_bank_arb #(
      .W        (W),
      .NREQ     (NREQ),
      .SYNC_MODE(1'b1)
   ) u_dut (
      .clk(clk),
      .r  (r),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural bank of synchronous set/reset D flops.
   always @(posedge clk) begin
      if (bus.bank_we) begin
         if (bus.bank_s) bank <= 8'hFF;
         else if (bus.bank_r) bank <= 8'h00;
         else bank <= bus.bank_d;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Scoreboard monitor: pop one expectation per ack; read data lands one cycle later.
   always @(negedge clk) begin
      if (bus.bank_we || bus.bank_s || bus.bank_r) begin
         chk("s_and_r_exclusive", 32'(bus.bank_s & bus.bank_r), 32'd0);
      end
      if (bus.ack != 4'b0000) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_ack got=%b exp=none", bus.ack);
         end else begin
            mon_e  = exp_q.pop_front();
            mon_oh = 4'b0001 << mon_e.idx;
            chk("ack_onehot", 32'(bus.ack), 32'(mon_oh));
            chk("gnt_at_ack", 32'(bus.gnt), 32'(mon_oh));
            if (mon_e.is_read) begin
               @(negedge clk);
               chk("rdata", 32'(bus.rdata), 32'(mon_e.rd));
               chk("ack_one_cycle", 32'(bus.ack), 32'd0);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      cyc++;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (bus.ack[i] && !hold[i]) req_v[i] = 1'b0;
      end
   endtask

   task automatic push_exp(input int idx, input bit is_read, input logic [7:0] rd);
      exp_t e;
      e.idx     = idx;
      e.is_read = is_read;
      e.rd      = rd;
      exp_q.push_back(e);
   endtask

   task automatic wait_ack(input int idx);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         step();
         if (bus.ack[idx]) got = 1'b1;
      end
      if (!got) begin
         n_checks++;
         n_err++;
         $display("FAIL ack_timeout got=none exp=ack[%0d]", idx);
      end
   endtask

   // One transaction from a lone requester, checking the ISSUE-cycle bank controls.
   task automatic txn(input int idx, input logic [1:0] c, input logic [7:0] d,
                      input logic [7:0] rd, output int lat);
      logic [3:0] oh;
      bit         got;
      oh = 4'b0001 << idx;
      push_exp(idx, c == CmdRead, rd);
      cmd_v[2*idx +: 2]   = c;
      wdata_v[8*idx +: 8] = d;
      req_v[idx]          = 1'b1;
      lat = 0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         step();
         lat++;
         if (bus.gnt[idx]) got = 1'b1;
      end
      if (!got) begin
         n_checks++;
         n_err++;
         $display("FAIL gnt_timeout got=none exp=gnt[%0d]", idx);
      end else begin
         chk("issue_gnt", 32'(bus.gnt), 32'(oh));
         chk("issue_we", 32'(bus.bank_we), 32'(c != CmdRead));
         chk("issue_d", 32'(bus.bank_d), 32'((c == CmdLoad) ? d : 8'h00));
         chk("issue_s", 32'(bus.bank_s), 32'(c == CmdSet));
         chk("issue_r", 32'(bus.bank_r), 32'(c == CmdClear));
      end
      wait_ack(idx);
   endtask

   initial begin
      int lat;
      int nack;
      int last;
      bit got;
      r        = 1'b1;
      req_v    = '0;
      cmd_v    = '0;
      wdata_v  = '0;
      hold     = '0;
      cyc      = 0;
      n_checks = 0;
      n_err    = 0;

      // Reset state.
      repeat (3) step();
      chk("rst_busy", 32'(bus.busy), 32'd1);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_we", 32'(bus.bank_we), 32'd0);
      chk("rst_bank_r", 32'(bus.bank_r), 32'd0);
      chk("rst_bank_s", 32'(bus.bank_s), 32'd0);
      chk("rst_bank_d", 32'(bus.bank_d), 32'd0);
      chk("rst_rdata", 32'(bus.rdata), 32'd0);
      chk("bank_sync", 32'(bus.bank_sync), 32'd1);

      // INIT clear cycle, then IDLE.
      r = 1'b0;
      step();
      chk("init_bank_r", 32'(bus.bank_r), 32'd1);
      chk("init_we", 32'(bus.bank_we), 32'd1);
      chk("init_busy", 32'(bus.busy), 32'd1);
      step();
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("init_bank_q", 32'(bank), 32'd0);
      chk("idle_bank_r", 32'(bus.bank_r), 32'd0);

      // Requester 2 LOAD 0xA5, then requester 0 reads it back.
      txn(2, CmdLoad, 8'hA5, 8'h00, lat);
      chk("gnt_latency", 32'(lat), 32'd1);
      txn(0, CmdRead, 8'h00, 8'hA5, lat);
      txn(3, CmdRead, 8'h00, 8'hA5, lat);  // leaves pointer at 0

      // 0 and 3 together; 0 re-requests with 1 joining -> order 0,1,3,0.
      push_exp(0, 1'b0, 8'h00);
      push_exp(1, 1'b1, 8'h11);
      push_exp(3, 1'b0, 8'h00);
      push_exp(0, 1'b1, 8'h22);
      cmd_v[1:0]     = CmdLoad;
      wdata_v[7:0]   = 8'h11;
      cmd_v[7:6]     = CmdLoad;
      wdata_v[31:24] = 8'h22;
      hold[0]        = 1'b1;
      req_v[0]       = 1'b1;
      req_v[3]       = 1'b1;
      wait_ack(0);
      cmd_v[1:0] = CmdRead;
      cmd_v[3:2] = CmdRead;
      req_v[1]   = 1'b1;
      hold[0]    = 1'b0;
      wait_ack(1);
      wait_ack(3);
      wait_ack(0);

      // SET / CLEAR from requester 1 with read-backs.
      txn(1, CmdSet, 8'h00, 8'h00, lat);
      txn(1, CmdRead, 8'h00, 8'hFF, lat);
      txn(1, CmdClear, 8'h00, 8'h00, lat);
      txn(1, CmdRead, 8'h00, 8'h00, lat);
      txn(3, CmdRead, 8'h00, 8'h00, lat);  // pointer back to 0

      // All four hold req: grants 0,1,2,3,0 with acks 3 cycles apart.
      push_exp(0, 1'b1, 8'h00);
      push_exp(1, 1'b1, 8'h00);
      push_exp(2, 1'b1, 8'h00);
      push_exp(3, 1'b1, 8'h00);
      push_exp(0, 1'b1, 8'h00);
      cmd_v = 8'hFF;
      hold  = 4'hF;
      req_v = 4'hF;
      nack  = 0;
      last  = 0;
      for (int k = 0; k < 40 && nack < 5; k++) begin
         step();
         if (bus.ack != 4'b0000) begin
            nack++;
            if (nack > 1) chk("ack_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            if (nack == 5) begin
               req_v = '0;
               hold  = '0;
            end
         end
      end
      chk("rr_ack_count", 32'(nack), 32'd5);

      // Reset during ISSUE of LOAD 0x3C aborts without ack; INIT clears the bank.
      step();
      step();
      cmd_v[5:4]     = CmdLoad;
      wdata_v[23:16] = 8'h3C;
      req_v[2]       = 1'b1;
      got            = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         step();
         if (bus.gnt[2]) got = 1'b1;
      end
      chk("abort_issue_seen", 32'(got), 32'd1);
      chk("abort_issue_d", 32'(bus.bank_d), 32'h3C);
      r = 1'b1;
      step();
      req_v[2] = 1'b0;
      chk("abort_we", 32'(bus.bank_we), 32'd0);
      chk("abort_s", 32'(bus.bank_s), 32'd0);
      chk("abort_r", 32'(bus.bank_r), 32'd0);
      chk("abort_ack", 32'(bus.ack), 32'd0);
      chk("abort_gnt", 32'(bus.gnt), 32'd0);
      r = 1'b0;
      step();
      chk("reinit_bank_r", 32'(bus.bank_r), 32'd1);
      step();
      chk("reinit_bank_q", 32'(bank), 32'd0);
      chk("reinit_busy", 32'(bus.busy), 32'd0);
      txn(0, CmdRead, 8'h00, 8'h00, lat);

      repeat (4) step();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
